pipeline_hazard_ctrl: RTL

Hazard and sequencing controller for the five-stage RV32I pipeline. It drives the enable, flush and PC-select controls of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four conditions:
- control-flow redirects (JAL, JALR, taken branch) resolved in EX;
- load-use data hazards, with a configurable load latency;
- instruction-memory wait states;
- data-memory wait states.

It replaces ad-hoc flush logic inside the pipeline registers: those registers only obey `*_en` and `*_flush`.

---
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard and sequencing controller for a five-stage RV32I
// pipeline. It drives the enable, flush and PC-select controls of the PC and the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves EX redirects, load-use
// hazards, imem wait states and dmem wait states.
// Optional build macro: HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_events performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1,   // load-use stall length, 1..7
  parameter int unsigned CNT_W    = 32   // performance counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             mem_access,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic             ex_branch_taken,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             pc_en,
  output logic             pc_sel_redirect,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [1:0]       state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;

  logic dstall, redirect, lu_hit;

  assign dstall   = mem_access & ~dmem_ready;
  assign redirect = ex_jal | ex_jalr | ex_branch_taken;
  assign lu_hit   = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

  assign state = state_q;

  // Next-state and control outputs; reset forces every control to its safe value.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    pc_en           = 1'b1;
    pc_sel_redirect = 1'b0;
    ifid_en         = 1'b1;
    idex_en         = 1'b1;
    exmem_en        = 1'b1;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    memwb_flush     = 1'b0;
    state_d         = state_q;
    lu_cnt_d        = lu_cnt_q;

    if (state_q == LU_STALL) begin
      if (dstall) begin
        // Memory freeze wins; the load-use countdown is paused.
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
      end else begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        lu_cnt_d   = lu_cnt_q - 3'd1;
        if (lu_cnt_q == 3'd1) state_d = RUN;
      end
    end else begin
      // RUN, MEM_WAIT (and any illegal encoding) share the RUN priority chain.
      if (dstall) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
        state_d     = MEM_WAIT;
      end else begin
        state_d = RUN;
        if (redirect) begin
          pc_sel_redirect = 1'b1;
          ifid_flush      = 1'b1;
          idex_flush      = 1'b1;
        end else if (lu_hit) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          lu_cnt_d   = LU_INIT;
          if (LOAD_LAT > 1) state_d = LU_STALL;
        end else if (!imem_ready) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
    end

    if (rst) begin
      pc_en           = 1'b0;
      pc_sel_redirect = 1'b0;
      ifid_en         = 1'b0;
      idex_en         = 1'b0;
      exmem_en        = 1'b0;
      ifid_flush      = 1'b1;
      idex_flush      = 1'b1;
      memwb_flush     = 1'b1;
    end
  end

  // State and load-use countdown registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q  <= RUN;
      lu_cnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_events_q;

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

  // Performance counters: PC-stall cycles and redirect flush cycles, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (!pc_en)          stall_cycles_q <= stall_cycles_q + 1'b1;
      if (pc_sel_redirect) flush_events_q <= flush_events_q + 1'b1;
    end
  end
`endif

endmodule
